// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage with req/ack data-memory handshake, timeout abort and MEM/WB register
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MEM_WB,
  input  logic [1:0]  MEM_M,
  input  logic [31:0] MEM_ALU_out,
  input  logic [31:0] DM_Wdata,
  input  logic [4:0]  MEM_writeReg,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [1:0]  WB_WB,
  output logic [31:0] WB_read_data,
  output logic [31:0] WB_ALU_out,
  output logic [4:0]  WB_writeReg
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             op, is_write, misaligned, at_limit, abort;

  assign op         = MEM_M[1] | MEM_M[0];
  assign is_write   = MEM_M[0];
  assign misaligned = op & (MEM_ALU_out[1:0] != 2'b00);
  // Last permitted wait cycle: an ack here still completes, otherwise the access is abandoned.
  assign at_limit   = (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT - 1));

  // Gating with rst keeps the request (and therefore the stall) low throughout reset.
  assign dm_req    = rst & op & ~misaligned;
  assign abort     = dm_req & ~dm_ack & at_limit;
  assign mem_stall = dm_req & ~dm_ack & ~at_limit;
  assign dm_we     = dm_req & is_write;
  assign dm_addr   = MEM_ALU_out;
  assign dm_wdata  = DM_Wdata;

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: enter WAIT on an unacked request, leave on ack, timeout or a vanished request.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (dm_req && !dm_ack) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (dm_ack || at_limit || !dm_req) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Sticky error: set by a misaligned access or a timeout abort, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_err <= 1'b0;
    end else if (misaligned || abort) begin
      mem_err <= 1'b1;
    end
  end

  // MEM/WB register: bubble while stalled, otherwise retire with squash rules for errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_WB        <= '0;
      WB_read_data <= '0;
      WB_ALU_out   <= '0;
      WB_writeReg  <= '0;
    end else if (mem_stall) begin
      WB_WB <= '0;
    end else begin
      WB_ALU_out  <= MEM_ALU_out;
      WB_writeReg <= MEM_writeReg;
      if (misaligned) begin
        WB_WB <= '0;
      end else if (abort) begin
        WB_read_data <= '0;
        WB_WB        <= is_write ? 2'b00 : MEM_WB;
      end else begin
        WB_WB <= MEM_WB;
        if (dm_req && dm_ack && !is_write) begin
          WB_read_data <= dm_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  MEM_WB, MEM_M;
  logic [31:0] MEM_ALU_out, DM_Wdata, dm_addr, dm_wdata, dm_rdata;
  logic [31:0] WB_read_data, WB_ALU_out;
  logic [4:0]  MEM_writeReg, WB_writeReg;
  logic        dm_req, dm_we, dm_ack, mem_stall, mem_err;
  logic [1:0]  WB_WB;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_wb;
  logic [31:0] exp_rd, exp_alu;
  logic [4:0]  exp_reg;
  logic        exp_err;

  int  req_n, stall_n, drv_bad, bub_bad;
  bit  hung;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .MEM_WB(MEM_WB), .MEM_M(MEM_M), .MEM_ALU_out(MEM_ALU_out),
    .DM_Wdata(DM_Wdata), .MEM_writeReg(MEM_writeReg), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_stall(mem_stall), .mem_err(mem_err), .WB_WB(WB_WB), .WB_read_data(WB_read_data),
    .WB_ALU_out(WB_ALU_out), .WB_writeReg(WB_writeReg)
  );

  always #5 clk = ~clk;

  // Cycles the memory sees a request: ack arrives on request cycle lat (0-based), capped by the timeout.
  function automatic int exp_req(input logic [1:0] m, input logic [31:0] a, input int lat);
    if (m == 2'b00 || a[1:0] != 2'b00) return 0;
    return (lat + 1 < TIMEOUT) ? lat + 1 : TIMEOUT;
  endfunction

  function automatic int exp_stall(input logic [1:0] m, input logic [31:0] a, input int lat);
    if (m == 2'b00 || a[1:0] != 2'b00) return 0;
    return (lat < TIMEOUT - 1) ? lat : TIMEOUT - 1;
  endfunction

  // Architectural effect of one retired instruction on the MEM/WB register and error flag.
  task automatic model_retire(input logic [1:0] m, input logic [1:0] wb, input logic [31:0] a,
                              input logic [4:0] wreg, input int lat, input logic [31:0] rd);
    bit is_op, is_wr, mis;
    is_op = (m != 2'b00);
    is_wr = m[0];
    mis   = is_op && (a[1:0] != 2'b00);
    exp_alu = a;
    exp_reg = wreg;
    if (mis) begin
      exp_wb  = 2'b00;
      exp_err = 1'b1;
    end else if (!is_op) begin
      exp_wb = wb;
    end else if (lat >= TIMEOUT) begin
      exp_rd  = 32'h0;
      exp_wb  = is_wr ? 2'b00 : wb;
      exp_err = 1'b1;
    end else begin
      exp_wb = wb;
      if (!is_wr) exp_rd = rd;
    end
  endtask

  // Present one instruction, act as a memory acking after lat cycles, run until it retires.
  task automatic run_instr(input logic [1:0] m, input logic [1:0] wb, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] wreg, input int lat,
                           input logic [31:0] rd);
    bit stalled;
    req_n = 0; stall_n = 0; drv_bad = 0; bub_bad = 0; hung = 1'b1;
    @(negedge clk);
    MEM_M = m; MEM_WB = wb; MEM_ALU_out = a; DM_Wdata = wd; MEM_writeReg = wreg;
    dm_ack = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      dm_ack   = dm_req && (c == lat);
      dm_rdata = (c == lat) ? rd : $urandom;
      #1;
      if (dm_req) begin
        req_n++;
        if (dm_we !== m[0] || dm_addr !== a || dm_wdata !== wd) drv_bad++;
      end
      stalled = (mem_stall === 1'b1);
      if (stalled) stall_n++;
      @(posedge clk);
      #1;
      if (!stalled) begin
        hung = 1'b0;
        break;
      end
      if (WB_WB !== 2'b00) bub_bad++;
      @(negedge clk);
    end
    dm_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    MEM_M = 2'b10; MEM_WB = 2'b11; MEM_ALU_out = 32'h100; DM_Wdata = 32'h0;
    MEM_writeReg = 5'd3; dm_ack = 1'b0; dm_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL reset_dm_req got %b exp 0", dm_req); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", mem_stall); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", mem_err); end
    checks++;
    if (WB_WB !== 2'b0 || WB_read_data !== 32'h0 || WB_ALU_out !== 32'h0 || WB_writeReg !== 5'h0) begin
      errors++;
      $display("FAIL reset_wb got %h/%h/%h/%h exp all zero", WB_WB, WB_read_data, WB_ALU_out, WB_writeReg);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_wb = 0; exp_rd = 0; exp_alu = 0; exp_reg = 0; exp_err = 0;
  endtask

  task automatic test_passthrough;
    run_instr(2'b00, 2'b10, 32'h0000_00A5, 32'h0, 5'd7, 99, 32'h0);
    model_retire(2'b00, 2'b10, 32'h0000_00A5, 5'd7, 99, 32'h0);
    checks++; if (req_n != 0 || stall_n != 0 || hung) begin errors++; $display("FAIL pass_req_stall got req=%0d stall=%0d hung=%0d exp 0/0/0", req_n, stall_n, hung); end
    checks++;
    if (WB_WB !== 2'b10 || WB_ALU_out !== 32'hA5 || WB_writeReg !== 5'd7) begin
      errors++;
      $display("FAIL pass_wb got %b/%h/%0d exp 10/a5/7", WB_WB, WB_ALU_out, WB_writeReg);
    end
  endtask

  task automatic test_zero_wait_load;
    run_instr(2'b10, 2'b11, 32'h100, 32'h0, 5'd9, 0, 32'hDEAD_BEEF);
    model_retire(2'b10, 2'b11, 32'h100, 5'd9, 0, 32'hDEAD_BEEF);
    checks++; if (req_n != 1 || stall_n != 0) begin errors++; $display("FAIL zw_req_stall got req=%0d stall=%0d exp 1/0", req_n, stall_n); end
    checks++; if (WB_read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zw_rdata got %h exp deadbeef", WB_read_data); end
    checks++; if (WB_WB !== 2'b11) begin errors++; $display("FAIL zw_wb got %b exp 11", WB_WB); end
  endtask

  task automatic test_store_3cycle;
    run_instr(2'b01, 2'b00, 32'h44, 32'h1234_5678, 5'd0, 2, 32'h0);
    model_retire(2'b01, 2'b00, 32'h44, 5'd0, 2, 32'h0);
    checks++; if (req_n != 3 || stall_n != 2) begin errors++; $display("FAIL st3_req_stall got req=%0d stall=%0d exp 3/2", req_n, stall_n); end
    checks++; if (drv_bad != 0 || bub_bad != 0) begin errors++; $display("FAIL st3_drive got drv_bad=%0d bub_bad=%0d exp 0/0", drv_bad, bub_bad); end
    checks++; if (mem_err !== 1'b0 || WB_ALU_out !== 32'h44) begin errors++; $display("FAIL st3_retire got err=%b alu=%h exp 0/44", mem_err, WB_ALU_out); end
  endtask

  task automatic test_timeout;
    run_instr(2'b10, 2'b11, 32'h200, 32'h0, 5'd4, 1000, 32'h0);
    model_retire(2'b10, 2'b11, 32'h200, 5'd4, 1000, 32'h0);
    checks++; if (req_n != 16 || stall_n != 15 || hung) begin errors++; $display("FAIL to_req_stall got req=%0d stall=%0d hung=%0d exp 16/15/0", req_n, stall_n, hung); end
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", mem_err); end
    checks++; if (WB_read_data !== 32'h0 || WB_WB !== 2'b11) begin errors++; $display("FAIL to_wb got rd=%h wb=%b exp 0/11", WB_read_data, WB_WB); end
  endtask

  task automatic test_misaligned;
    run_instr(2'b10, 2'b11, 32'h102, 32'h0, 5'd5, 0, 32'h0);
    model_retire(2'b10, 2'b11, 32'h102, 5'd5, 0, 32'h0);
    checks++; if (req_n != 0 || stall_n != 0) begin errors++; $display("FAIL mis_req_stall got req=%0d stall=%0d exp 0/0", req_n, stall_n); end
    checks++; if (WB_WB !== 2'b00 || mem_err !== 1'b1) begin errors++; $display("FAIL mis_wb_err got wb=%b err=%b exp 00/1", WB_WB, mem_err); end
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk);
    MEM_M = 2'b10; MEM_WB = 2'b11; MEM_ALU_out = 32'h300; MEM_writeReg = 5'd6; dm_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (dm_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL rmw_req got req=%b stall=%b exp 0/0", dm_req, mem_stall); end
    checks++;
    if (WB_WB !== 2'b0 || WB_read_data !== 32'h0 || WB_ALU_out !== 32'h0 || WB_writeReg !== 5'h0 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL rmw_clear got %h/%h/%h/%h err=%b exp all zero", WB_WB, WB_read_data, WB_ALU_out, WB_writeReg, mem_err);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_wb = 0; exp_rd = 0; exp_alu = 0; exp_reg = 0; exp_err = 0;
    run_instr(2'b10, 2'b10, 32'h304, 32'h0, 5'd8, 1, 32'hCAFE_F00D);
    model_retire(2'b10, 2'b10, 32'h304, 5'd8, 1, 32'hCAFE_F00D);
    checks++; if (req_n != 2 || stall_n != 1) begin errors++; $display("FAIL rmw_after_req got req=%0d stall=%0d exp 2/1", req_n, stall_n); end
    checks++; if (WB_read_data !== 32'hCAFE_F00D || WB_WB !== 2'b10 || mem_err !== 1'b0) begin errors++; $display("FAIL rmw_after_wb got rd=%h wb=%b err=%b exp cafef00d/10/0", WB_read_data, WB_WB, mem_err); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  m, wb;
    logic [31:0] a, wd, rd;
    logic [4:0]  wreg;
    int          lat, sel, er, es;
    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom_range(0, 3));
      wb = 2'($urandom_range(0, 3));
      a = {$urandom} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      wd = $urandom; rd = $urandom; wreg = 5'($urandom);
      sel = $urandom_range(0, 9);
      lat = (sel <= 6) ? $urandom_range(0, 3) : (sel == 7) ? TIMEOUT - 1 : (sel == 8) ? TIMEOUT : 40;
      er = exp_req(m, a, lat);
      es = exp_stall(m, a, lat);
      run_instr(m, wb, a, wd, wreg, lat, rd);
      model_retire(m, wb, a, wreg, lat, rd);
      checks++; if (hung || req_n != er || stall_n != es) begin errors++; $display("FAIL b2b_hs[%0d] got req=%0d stall=%0d hung=%0d exp %0d/%0d/0", i, req_n, stall_n, hung, er, es); end
      checks++; if (drv_bad != 0 || bub_bad != 0) begin errors++; $display("FAIL b2b_drive[%0d] got drv_bad=%0d bub_bad=%0d exp 0/0", i, drv_bad, bub_bad); end
      checks++; if (WB_WB !== exp_wb) begin errors++; $display("FAIL b2b_wb[%0d] got %b exp %b", i, WB_WB, exp_wb); end
      checks++; if (WB_read_data !== exp_rd) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, WB_read_data, exp_rd); end
      checks++; if (WB_ALU_out !== exp_alu || WB_writeReg !== exp_reg) begin errors++; $display("FAIL b2b_alu_reg[%0d] got %h/%0d exp %h/%0d", i, WB_ALU_out, WB_writeReg, exp_alu, exp_reg); end
      checks++; if (mem_err !== exp_err) begin errors++; $display("FAIL b2b_err[%0d] got %b exp %b", i, mem_err, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_zero_wait_load();
    test_store_3cycle();
    test_timeout();
    test_misaligned();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
